// File: rtl/set_mode_controller.sv
`default_nettype none
// ============================================================================
// Module   : set_mode_controller
// Purpose  : Turns debounced MODE/INC/ALARM levels into arbitrated commands,
//            walks the set-mode FSM and emits one-tick inc/load strobes.
// Options  : SET_TIMEOUT_EN - enables the idle counter and auto-return to RUN.
// Revision : 1.0 - initial release
// ============================================================================
module set_mode_controller #(
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic       half_second,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       alarm_btn,
  output logic [2:0] mode,
  output logic       setting,
  output logic       hr_inc,
  output logic       min_inc,
  output logic       al_hr_inc,
  output logic       al_min_inc,
  output logic       time_load,
  output logic       alarm_load,
  output logic       alarm_en
);

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_SET_HR     = 3'd1,
    ST_SET_MIN    = 3'd2,
    ST_SET_AL_HR  = 3'd3,
    ST_SET_AL_MIN = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_mode_prev;
  logic       r_inc_prev;
  logic       r_alarm_prev;

  logic       r_setting;
  logic [3:0] r_inc;          // {hr, min, al_hr, al_min}
  logic       r_time_load;
  logic       r_alarm_load;
  logic       r_alarm_en;

  logic [3:0] w_inc_nxt;
  logic       w_time_load_nxt;
  logic       w_alarm_load_nxt;
  logic       w_alarm_en_nxt;

  logic       w_mode_edge;
  logic       w_inc_raw;
  logic       w_inc_edge;
  logic       w_alarm_edge;
  logic       w_timeout;

  // MODE > INC > ALARM; losers on the same tick are dropped, not queued.
  assign w_mode_edge  = mode_btn & ~r_mode_prev;
  assign w_inc_raw    = inc_btn & ~r_inc_prev;
  assign w_inc_edge   = w_inc_raw & ~w_mode_edge;
  assign w_alarm_edge = alarm_btn & ~r_alarm_prev & ~w_mode_edge & ~w_inc_raw;

`ifdef SET_TIMEOUT_EN
  localparam int c_idle_w = $clog2(TIMEOUT_CYCLES);

  logic [c_idle_w-1:0] r_idle;

  assign w_timeout = (r_idle == c_idle_w'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge half_second or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if ((w_next_state == ST_RUN) || (w_next_state != r_state) || w_inc_edge) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + c_idle_w'(1);
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYCLES < 2);
`endif

  always_ff @(posedge half_second or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_mode_prev  <= 1'b0;
      r_inc_prev   <= 1'b0;
      r_alarm_prev <= 1'b0;
      r_setting    <= 1'b0;
      r_inc        <= 4'b0000;
      r_time_load  <= 1'b0;
      r_alarm_load <= 1'b0;
      r_alarm_en   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_mode_prev  <= mode_btn;
      r_inc_prev   <= inc_btn;
      r_alarm_prev <= alarm_btn;
      r_setting    <= (w_next_state != ST_RUN);
      r_inc        <= w_inc_nxt;
      r_time_load  <= w_time_load_nxt;
      r_alarm_load <= w_alarm_load_nxt;
      r_alarm_en   <= w_alarm_en_nxt;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_inc_nxt        = 4'b0000;
    w_time_load_nxt  = 1'b0;
    w_alarm_load_nxt = 1'b0;
    w_alarm_en_nxt   = r_alarm_en;

    case (r_state)
      ST_RUN: begin
        if (w_mode_edge) begin
          w_next_state = ST_SET_HR;
        end else if (w_alarm_edge) begin
          w_alarm_en_nxt = ~r_alarm_en;
        end
      end

      ST_SET_HR: begin
        if (w_mode_edge) begin
          w_next_state = ST_SET_MIN;
        end else if (w_inc_edge) begin
          w_inc_nxt = 4'b1000;
        end else if (w_timeout) begin
          w_next_state    = ST_RUN;
          w_time_load_nxt = 1'b1;
        end
      end

      ST_SET_MIN: begin
        if (w_mode_edge) begin
          w_next_state    = ST_SET_AL_HR;
          w_time_load_nxt = 1'b1;
        end else if (w_inc_edge) begin
          w_inc_nxt = 4'b0100;
        end else if (w_timeout) begin
          w_next_state    = ST_RUN;
          w_time_load_nxt = 1'b1;
        end
      end

      ST_SET_AL_HR: begin
        if (w_mode_edge) begin
          w_next_state = ST_SET_AL_MIN;
        end else if (w_inc_edge) begin
          w_inc_nxt = 4'b0010;
        end else if (w_timeout) begin
          w_next_state     = ST_RUN;
          w_alarm_load_nxt = 1'b1;
        end
      end

      ST_SET_AL_MIN: begin
        if (w_mode_edge || (!w_inc_edge && w_timeout)) begin
          w_next_state     = ST_RUN;
          w_alarm_load_nxt = 1'b1;
        end else if (w_inc_edge) begin
          w_inc_nxt = 4'b0001;
        end
      end

      // Unreachable encodings recover silently.
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  assign mode       = r_state;
  assign setting    = r_setting;
  assign hr_inc     = r_inc[3];
  assign min_inc    = r_inc[2];
  assign al_hr_inc  = r_inc[1];
  assign al_min_inc = r_inc[0];
  assign time_load  = r_time_load;
  assign alarm_load = r_alarm_load;
  assign alarm_en   = r_alarm_en;

endmodule
`default_nettype wire

// File: tb/tb_set_mode_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_mode_controller
// Purpose  : Directed and randomized checks of set_mode_controller against a
//            behavioural model of the button/mode rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_mode_controller;

  localparam int c_timeout = 20;

  logic       half_second = 1'b0;
  logic       reset;
  logic       mode_btn, inc_btn, alarm_btn;
  logic [2:0] mode;
  logic       setting, hr_inc, min_inc, al_hr_inc, al_min_inc;
  logic       time_load, alarm_load, alarm_en;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_mode;
  bit m_alarm_en;
  bit m_pm, m_pi, m_pa;
  int m_idle;
  logic [3:0] m_inc;
  bit m_tl, m_al;

  set_mode_controller #(.TIMEOUT_CYCLES(c_timeout)) dut (
    .half_second(half_second),
    .reset      (reset),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .alarm_btn  (alarm_btn),
    .mode       (mode),
    .setting    (setting),
    .hr_inc     (hr_inc),
    .min_inc    (min_inc),
    .al_hr_inc  (al_hr_inc),
    .al_min_inc (al_min_inc),
    .time_load  (time_load),
    .alarm_load (alarm_load),
    .alarm_en   (alarm_en)
  );

  always #5 half_second = ~half_second;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit timeout_enabled();
`ifdef SET_TIMEOUT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_alarm_en = 0; m_pm = 0; m_pi = 0; m_pa = 0; m_idle = 0;
    m_inc = '0; m_tl = 0; m_al = 0;
  endtask

  // One tick of the front-panel rules, applied to the levels sampled at the edge.
  task automatic model_step(input bit mb, input bit ib, input bit ab);
    bit me, ie, ae;
    me = mb && !m_pm;
    ie = ib && !m_pi && !me;
    ae = ab && !m_pa && !me && !(ib && !m_pi);
    m_pm = mb; m_pi = ib; m_pa = ab;
    m_inc = '0; m_tl = 0; m_al = 0;
    if (me) begin
      m_tl   = (m_mode == 2);
      m_al   = (m_mode == 4);
      m_mode = (m_mode + 1) % 5;
      m_idle = 0;
    end else if (m_mode == 0) begin
      if (ae) m_alarm_en = !m_alarm_en;
      m_idle = 0;
    end else if (ie) begin
      m_inc  = 4'b1000 >> (m_mode - 1);
      m_idle = 0;
    end else if (timeout_enabled() && m_idle == c_timeout - 1) begin
      if (m_mode <= 2) m_tl = 1; else m_al = 1;
      m_mode = 0;
      m_idle = 0;
    end else begin
      m_idle++;
    end
  endtask

  task automatic compare_all();
    check("mode",     32'(mode),       32'(m_mode));
    check("setting",  32'(setting),    32'(m_mode != 0));
    check("inc",      32'({hr_inc, min_inc, al_hr_inc, al_min_inc}), 32'(m_inc));
    check("tload",    32'(time_load),  32'(m_tl));
    check("aload",    32'(alarm_load), 32'(m_al));
    check("alarm_en", 32'(alarm_en),   32'(m_alarm_en));
  endtask

  // Drive levels, let one rising edge sample them, then check 1 time unit later.
  task automatic tick(input bit mb, input bit ib, input bit ab);
    mode_btn = mb; inc_btn = ib; alarm_btn = ab;
    @(posedge half_second);
    #1;
    model_step(mb, ib, ab);
    compare_all();
  endtask

  task automatic apply_reset();
    mode_btn = 0; inc_btn = 0; alarm_btn = 0;
    reset = 1;
    @(posedge half_second);
    #2;
    reset = 0;
    model_reset();
  endtask

  task automatic press_mode(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, exit_at, n_al, n_str;
    logic [2:0] exp_seq [5];
    exp_seq[0] = 3'd1; exp_seq[1] = 3'd2; exp_seq[2] = 3'd3;
    exp_seq[3] = 3'd4; exp_seq[4] = 3'd0;

    reset = 1; mode_btn = 0; inc_btn = 0; alarm_btn = 0;
    model_reset();
    #3;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_setting", 32'(setting), 32'd0);
    check("rst_strobes", 32'({hr_inc, min_inc, al_hr_inc, al_min_inc, time_load, alarm_load, alarm_en}), 32'd0);
    apply_reset();

    // ALARM toggles in RUN
    tick(0, 0, 1);
    check("al_on", 32'(alarm_en), 32'd1);
    tick(0, 0, 0);
    tick(0, 0, 1);
    check("al_off", 32'(alarm_en), 32'd0);
    tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);

    // Asynchronous reset mid-edit in SET_MIN
    press_mode(2);
    check("pre_rst_mode", 32'(mode), 32'd2);
    #2;
    reset = 1;
    #1;
    check("async_mode", 32'(mode), 32'd0);
    check("async_alen", 32'(alarm_en), 32'd0);
    check("async_tload", 32'(time_load), 32'd0);
    apply_reset();
    tick(0, 0, 0);

    // Full MODE cycle with load strobes on the exit ticks only
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0);
      check("seq_mode", 32'(mode), 32'(exp_seq[i]));
      check("seq_tload", 32'(time_load), 32'(i == 2));
      check("seq_aload", 32'(alarm_load), 32'(i == 4));
      tick(0, 0, 0);
    end

    // Held INC produces one pulse per press
    press_mode(1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(0, 1, 0); cnt += int'(hr_inc); end
    tick(0, 0, 0); cnt += int'(hr_inc);
    tick(0, 1, 0); cnt += int'(hr_inc);
    tick(0, 0, 0); cnt += int'(hr_inc);
    check("hr_inc_cnt", 32'(cnt), 32'd2);

    // MODE and INC together in SET_MIN: MODE wins
    press_mode(1);
    tick(1, 1, 0);
    check("mi_mode", 32'(mode), 32'd3);
    check("mi_mininc", 32'(min_inc), 32'd0);
    check("mi_tload", 32'(time_load), 32'd1);
    tick(0, 0, 0);
    press_mode(2);
    check("back_run", 32'(mode), 32'd0);

    if (timeout_enabled()) begin
      for (int pass = 0; pass < 2; pass++) begin
        press_mode(2);
        tick(1, 0, 0);
        check("to_entry", 32'(mode), 32'd3);
        exit_at = -1; n_al = 0;
        for (int n = 1; n <= 60 && exit_at < 0; n++) begin
          tick(0, (pass == 1) && (n == 15), 0);
          n_al += int'(alarm_load);
          if (mode == 3'd0) exit_at = n;
        end
        check("to_exit_tick", 32'(exit_at), (pass == 0) ? 32'd20 : 32'd35);
        check("to_aload_cnt", 32'(n_al), 32'd1);
      end
    end else begin
      press_mode(1);
      n_str = 0;
      for (int n = 0; n < 100; n++) begin
        tick(0, 0, 0);
        n_str += int'(hr_inc) + int'(min_inc) + int'(al_hr_inc) + int'(al_min_inc)
               + int'(time_load) + int'(alarm_load);
      end
      check("noto_mode", 32'(mode), 32'd1);
      check("noto_strobes", 32'(n_str), 32'd0);
      press_mode(4);
    end

    // Randomized levels against the model
    for (int n = 0; n < 3000; n++) begin
      bit mb, ib, ab;
      mb = mode_btn; ib = inc_btn; ab = alarm_btn;
      if ($urandom_range(0, 5) == 0) mb = !mb;
      if ($urandom_range(0, 2) == 0) ib = !ib;
      if ($urandom_range(0, 3) == 0) ab = !ab;
      // long quiet stretches let the idle timeout fire
      if ($urandom_range(0, 99) < 2) begin
        for (int q = 0; q < 25; q++) tick(0, 0, 0);
      end
      tick(mb, ib, ab);
      check("onehot_inc", 32'($countones({hr_inc, min_inc, al_hr_inc, al_min_inc}) <= 1), 32'd1);
      check("excl_load", 32'(time_load & alarm_load), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
